// File: rtl/hack_mem_ctrl.sv
// hack_mem_ctrl: Hack CPU memory-map controller.
// Decodes the 15-bit Hack word address into data RAM, screen memory, the
// keyboard register and an invalid hole. It drives two synchronous memories
// that have one cycle of read latency.
// Writes complete in the cycle they are accepted. Reads take three cycles:
// IDLE (accept), RD_WAIT (memory latency), RESP (rvalid).
// Optional feature: define HACK_MEM_ERR_EN to enable the sticky err flag.
// When the macro is undefined, err is tied low.
module hack_mem_ctrl #(
    parameter int RAM_AW = 14,
    parameter int SCR_AW = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [14:0]       cpu_addr,
    input  logic [15:0]       cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [15:0]       cpu_rdata,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [15:0]       ram_din,
    input  logic [15:0]       ram_dout,
    output logic              scr_we,
    output logic [SCR_AW-1:0] scr_addr,
    output logic [15:0]       scr_din,
    input  logic [15:0]       scr_dout,
    input  logic [15:0]       kbd_code,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RESP    = 2'd2
    } state_t;

    localparam logic [1:0] REG_RAM = 2'd0;
    localparam logic [1:0] REG_SCR = 2'd1;
    localparam logic [1:0] REG_KBD = 2'd2;
    localparam logic [1:0] REG_INV = 2'd3;

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  w_region;
    logic [1:0]  r_region;
    logic [15:0] r_rdata;
    logic [15:0] r_kbd;
    logic        w_accept;

    // Decode the CPU address into one of the four regions.
    always_comb begin
        w_region = REG_INV;
        if (cpu_addr[14] == 1'b0) begin
            w_region = REG_RAM;
        end else if (cpu_addr[13] == 1'b0) begin
            w_region = REG_SCR;
        end else if (cpu_addr == 15'h6000) begin
            w_region = REG_KBD;
        end else begin
            w_region = REG_INV;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state: only accepted reads leave IDLE; the read path always returns to IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !cpu_we) begin
                    w_next_state = ST_RD_WAIT;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RD_WAIT: w_next_state = ST_RESP;
            ST_RESP:    w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake and write strobes, which acceptance gates so they are never active outside IDLE.
    always_comb begin
        cpu_ready  = (r_state == ST_IDLE) && !rst;
        w_accept   = cpu_req && cpu_ready;
        cpu_rvalid = (r_state == ST_RESP);
        ram_we     = w_accept && cpu_we && (w_region == REG_RAM);
        scr_we     = w_accept && cpu_we && (w_region == REG_SCR);
    end

    // The memories register the address themselves, so the address and data buses follow the CPU directly.
    assign ram_addr  = cpu_addr[RAM_AW-1:0];
    assign ram_din   = cpu_wdata;
    assign scr_addr  = cpu_addr[SCR_AW-1:0];
    assign scr_din   = cpu_wdata;
    assign cpu_rdata = r_rdata;

    // Remember which region an accepted read targets, for use in RD_WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_region <= REG_INV;
        end else if (w_accept && !cpu_we) begin
            r_region <= w_region;
        end else begin
            r_region <= r_region;
        end
    end

    // Sample the asynchronous keyboard code every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kbd <= 16'h0000;
        end else begin
            r_kbd <= kbd_code;
        end
    end

    // Capture the read response at the RD_WAIT->RESP edge; hold it until the next read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= 16'h0000;
        end else if (r_state == ST_RD_WAIT) begin
            case (r_region)
                REG_RAM: r_rdata <= ram_dout;
                REG_SCR: r_rdata <= scr_dout;
                REG_KBD: r_rdata <= r_kbd;
                default: r_rdata <= 16'h0000;
            endcase
        end else begin
            r_rdata <= r_rdata;
        end
    end

`ifdef HACK_MEM_ERR_EN
    logic r_err;

    // Sticky error: any accepted access to the invalid hole, or a write to the keyboard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept && ((w_region == REG_INV) ||
                                  ((w_region == REG_KBD) && cpu_we))) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_hack_mem_ctrl.sv
// Self-checking bench for hack_mem_ctrl, using behavioural one-cycle-latency memories.
module tb_hack_mem_ctrl;

`ifdef HACK_MEM_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [14:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ready;
    logic        cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        ram_we;
    logic [13:0] ram_addr;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;
    logic        scr_we;
    logic [12:0] scr_addr;
    logic [15:0] scr_din;
    logic [15:0] scr_dout;
    logic [15:0] kbd_code;
    logic        err;

    logic [15:0] ram_mem [0:16383];
    logic [15:0] scr_mem [0:8191];
    logic [15:0] sb [$];

    int errors = 0;
    int checks = 0;

    hack_mem_ctrl #(.RAM_AW(14), .SCR_AW(13)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .scr_we(scr_we), .scr_addr(scr_addr), .scr_din(scr_din), .scr_dout(scr_dout),
        .kbd_code(kbd_code), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous memories with one cycle of read latency.
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
        if (scr_we) scr_mem[scr_addr] <= scr_din;
        scr_dout <= scr_mem[scr_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write with the expected strobe pattern and target address; then check that the strobes drop and the controller stays in IDLE.
    task automatic wr(input logic [14:0] a, input logic [15:0] d,
                      input logic exp_ram, input logic exp_scr, input logic [13:0] exp_addr,
                      input string tag);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        #1;
        chk({tag, "_ready"}, 32'(cpu_ready), 32'd1);
        chk({tag, "_ram_we"}, 32'(ram_we), 32'(exp_ram));
        chk({tag, "_scr_we"}, 32'(scr_we), 32'(exp_scr));
        if (exp_ram) chk({tag, "_ram_addr"}, 32'(ram_addr), 32'(exp_addr));
        if (exp_scr) chk({tag, "_scr_addr"}, 32'(scr_addr), 32'(exp_addr));
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0;
        #1;
        chk({tag, "_ram_we_off"}, 32'(ram_we), 32'd0);
        chk({tag, "_scr_we_off"}, 32'(scr_we), 32'd0);
        chk({tag, "_idle"}, 32'(cpu_ready), 32'd1);
        chk({tag, "_no_rvalid"}, 32'(cpu_rvalid), 32'd0);
    endtask

    // Read with a write request held during RD_WAIT (which must be ignored); check that the response arrives two cycles after acceptance.
    task automatic rd(input logic [14:0] a, input logic [15:0] e, input string tag);
        logic [15:0] exp_v;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
        #1;
        chk({tag, "_ready"}, 32'(cpu_ready), 32'd1);
        chk({tag, "_no_strobe"}, 32'({ram_we, scr_we}), 32'd0);
        sb.push_back(e);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0003; cpu_wdata = 16'hDEAD;
        #1;
        chk({tag, "_wait_rvalid"}, 32'(cpu_rvalid), 32'd0);
        chk({tag, "_wait_ready"}, 32'(cpu_ready), 32'd0);
        chk({tag, "_wait_strobe"}, 32'({ram_we, scr_we}), 32'd0);
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0;
        #1;
        chk({tag, "_rvalid"}, 32'(cpu_rvalid), 32'd1);
        chk({tag, "_resp_ready"}, 32'(cpu_ready), 32'd0);
        chk({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
        exp_v = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
        chk({tag, "_rdata"}, 32'(cpu_rdata), 32'(exp_v));
        @(posedge clk); #1;
        chk({tag, "_rvalid_off"}, 32'(cpu_rvalid), 32'd0);
        chk({tag, "_back_idle"}, 32'(cpu_ready), 32'd1);
        chk({tag, "_rdata_hold"}, 32'(cpu_rdata), 32'(exp_v));
    endtask

    initial begin
        int acc [2];
        int n_acc;
        int n_resp;
        logic [15:0] exp_v;

        // Reset state, with a request already pending.
        rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0005;
        cpu_wdata = 16'h1234; kbd_code = 16'h0000;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_ready", 32'(cpu_ready), 32'd0);
        chk("rst_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst_rdata", 32'(cpu_rdata), 32'h0000);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_strobes", 32'({ram_we, scr_we}), 32'd0);
        rst = 1'b0;

        // Write then read back RAM; the write is accepted on the first edge after reset is released.
        wr(15'h0005, 16'h1234, 1'b1, 1'b0, 14'h0005, "ram_wr");
        rd(15'h0005, 16'h1234, "ram_rd");
        rd(15'h0003, 16'hxxxx, "ram3_rd_unwritten");
        // The read above only confirms timing; RAM[3] is then written with a known value.
        wr(15'h0003, 16'h0BEE, 1'b1, 1'b0, 14'h0003, "ram3_wr");
        rd(15'h0003, 16'h0BEE, "ram3_rd");

        // Screen write and read back, plus address truncation at the top of each region.
        wr(15'h4000, 16'hFFFF, 1'b0, 1'b1, 14'h0000, "scr_wr");
        rd(15'h4000, 16'hFFFF, "scr_rd");
        wr(15'h5FFF, 16'h00FF, 1'b0, 1'b1, 14'h1FFF, "scr_top_wr");
        rd(15'h5FFF, 16'h00FF, "scr_top_rd");
        wr(15'h3FFF, 16'hC0DE, 1'b1, 1'b0, 14'h3FFF, "ram_top_wr");
        rd(15'h3FFF, 16'hC0DE, "ram_top_rd");
        chk("err_clean", 32'(err), 32'd0);

        // Keyboard read, then an illegal keyboard write.
        kbd_code = 16'h0041;
        @(posedge clk); #1;
        rd(15'h6000, 16'h0041, "kbd_rd");
        chk("err_after_kbd_rd", 32'(err), 32'd0);
        wr(15'h6000, 16'h9999, 1'b0, 1'b0, 14'h0000, "kbd_wr");
        chk("err_kbd_wr", 32'(err), 32'(ERR_EN));

        // Invalid-hole read and write.
        rd(15'h7FFF, 16'h0000, "inv_rd");
        chk("err_inv", 32'(err), 32'(ERR_EN));
        wr(15'h7000, 16'h5A5A, 1'b0, 1'b0, 14'h0000, "inv_wr");

        // Reset asserted during RD_WAIT aborts the read.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0005;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_ready", 32'(cpu_ready), 32'd0);
        chk("abort_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("abort_rdata", 32'(cpu_rdata), 32'h0000);
        chk("abort_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("abort_no_rvalid", 32'(cpu_rvalid), 32'd0);
            chk("abort_idle", 32'(cpu_ready), 32'd1);
            @(posedge clk); #1;
        end

        // Back-to-back reads with cpu_req held high: one read accepted every third cycle, responses in order.
        wr(15'h0001, 16'hAAAA, 1'b1, 1'b0, 14'h0001, "pipe_wr1");
        wr(15'h0002, 16'h5555, 1'b1, 1'b0, 14'h0002, "pipe_wr2");
        sb.push_back(16'hAAAA);
        sb.push_back(16'h5555);
        n_acc = 0; n_resp = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0001;
        #1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cpu_rvalid) begin
                chk("pipe_resp_ready", 32'(cpu_ready), 32'd0);
                exp_v = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
                chk("pipe_rdata", 32'(cpu_rdata), 32'(exp_v));
                n_resp++;
            end
            if (cpu_ready && cpu_req) begin
                if (n_acc < 2) acc[n_acc] = cyc;
                n_acc++;
            end
            @(posedge clk); #1;
            if (n_acc == 1) cpu_addr = 15'h0002;
            if (n_acc >= 2) cpu_req = 1'b0;
            #1;
        end
        chk("pipe_n_acc", 32'(n_acc), 32'd2);
        chk("pipe_spacing", 32'(acc[1] - acc[0]), 32'd3);
        chk("pipe_n_resp", 32'(n_resp), 32'd2);
        chk("pipe_sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hack_mem_ctrl.md
HACK_MEM_CTRL -- requirements
Module: hack_mem_ctrl

Interface
REQ-001 SHALL have parameter RAM_AW, default 14, meaning data RAM word-address width (16K words, 0x0000-0x3FFF).
REQ-002 SHALL have parameter SCR_AW, default 13, meaning screen memory word-address width (8K words, 0x4000-0x5FFF).
REQ-003 SHALL have one clock and an asynchronous, active-high reset, named and ordered first as follows.
REQ-004 clk  in  1  single clock; all state on posedge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 cpu_req  in  1  CPU access request.
REQ-007 cpu_we  in  1  1 = write, 0 = read; valid with cpu_req.
REQ-008 cpu_addr  in  15  Hack word address.
REQ-009 cpu_wdata  in  16  write data.
REQ-010 cpu_ready  out  1  request accepted on this edge when cpu_req=1.
REQ-011 cpu_rvalid  out  1  one-cycle read-response strobe.
REQ-012 cpu_rdata  out  16  read data, valid when cpu_rvalid=1.
REQ-013 ram_we / ram_addr / ram_din  out  1 / RAM_AW / 16  drive synchronous data RAM.
REQ-014 ram_dout  in  16  data RAM read port, one-cycle latency.
REQ-015 scr_we / scr_addr / scr_din  out  1 / SCR_AW / 16  drive synchronous screen memory.
REQ-016 scr_dout  in  16  screen read port, one-cycle latency.
REQ-017 kbd_code  in  16  raw keyboard scan code, asynchronous to CPU accesses.
REQ-018 err  out  1  sticky access-error flag (see Configuration).

Function
REQ-019 Address map: 0x0000-0x3FFF RAM; 0x4000-0x5FFF screen; 0x6000 KBD; 0x6001-0x7FFF invalid.
REQ-020 FSM states IDLE, RD_WAIT, RESP; cpu_ready=1 only in IDLE and rst deasserted.
REQ-021 Acceptance = cpu_req & cpu_ready at a posedge; memory strobes are combinational from cpu_* and gated by acceptance.
REQ-022 Accepted write: RAM/screen write strobe for that cycle only; address truncated to RAM_AW/SCR_AW bits; FSM stays IDLE; no rvalid.
REQ-023 Writes to KBD or invalid addresses: no strobe asserted, data dropped, FSM stays IDLE.
REQ-024 Accepted read: region registered, IDLE->RD_WAIT; RD_WAIT->RESP unconditionally, capturing cpu_rdata from selected source; RESP->IDLE unconditionally.
REQ-025 cpu_rvalid=1 exactly in RESP; response presented 2 cycles after acceptance edge; read throughput one per 3 cycles.
REQ-026 cpu_rdata holds last response value until next capture.
REQ-027 kbd_code registered every cycle into kbd_reg; KBD read returns kbd_reg value at the RD_WAIT->RESP edge.
REQ-028 Invalid-address read returns 0x0000 with normal rvalid timing.
REQ-029 cpu_req in RD_WAIT/RESP ignored (cpu_ready=0); no strobes asserted.
REQ-030 ram_we and scr_we never both 1; neither asserted outside IDLE.

Reset
REQ-031 On rst: state=IDLE, cpu_rvalid=0, cpu_rdata=0x0000, kbd_reg=0x0000, err=0, cpu_ready=0, all strobes 0.
REQ-032 rst during RD_WAIT or RESP aborts the read; no rvalid issued after release.
REQ-033 First access accepted on first posedge with rst low.

Configuration
REQ-034 Macro HACK_MEM_ERR_EN: when defined, err sets on accepted access to 0x6001-0x7FFF or write to 0x6000, stays set until rst.
REQ-035 Without HACK_MEM_ERR_EN: err tied 0, port retained, no error logic.

Verification
REQ-036 Write 0x1234 to 0x0005, then read 0x0005 -> ram_we pulse once; cpu_rvalid 2 cycles after acceptance with cpu_rdata=0x1234.
REQ-037 Write 0xFFFF to 0x4000, read 0x4000 -> scr_we=1, scr_addr=0, ram_we=0; rdata=0xFFFF.
REQ-038 kbd_code=0x0041 held, read 0x6000 -> rdata=0x0041; write 0x6000 -> no strobes, err=1 only with HACK_MEM_ERR_EN.
REQ-039 Read 0x7FFF -> rdata=0x0000, rvalid timing normal; err=1 with macro, 0 without.
REQ-040 Read accepted, rst pulsed in RD_WAIT -> cpu_rvalid stays 0, state IDLE, cpu_rdata=0x0000.
REQ-041 cpu_req held high with reads to 0x0001,0x0002 -> accepts every 3rd cycle, cpu_ready=0 in RD_WAIT/RESP, responses in order.
